// File: rtl/pipe_stage.sv
// Single pipeline stage with one skid entry, stall-vector control, flush and a
// saturating counter of cycles where the stage presents no valid output.
module pipe_stage #(
   parameter int DATA_W      = 32,
   parameter int STALL_W     = 6,
   parameter int STAGE       = 2,
   parameter int ZERO_BUBBLE = 1,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   bubble_cnt
);

   // Downstream stall bit STAGE+1 must exist inside the stall vector.
   generate
      if (STAGE < 0 || STAGE > STALL_W - 2 || DATA_W < 1) begin : gIllegalParams
         $error("pipe_stage: illegal parameters (need 0 <= STAGE <= STALL_W-2, DATA_W >= 1)");
      end
   endgenerate

   logic              mainV_q, mainV_d;
   logic [DATA_W-1:0] mainD_q, mainD_d;
   logic              skidV_q, skidV_d;
   logic [DATA_W-1:0] skidD_q, skidD_d;
   logic [1:0]        occ_q, occ_d;
   logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;

   logic ownStall;
   logic downStall;
   logic accept;
   logic take;
   logic unusedStall;

   assign ownStall    = stall[STAGE];
   assign downStall   = stall[STAGE+1];
   assign unusedStall = ^stall;

   assign in_ready = !skidV_q && !ownStall && !flush;
   assign accept   = in_valid && in_ready;
   assign take     = mainV_q && out_ready && !downStall;

   // Emptying main also zeroes its payload when ZERO_BUBBLE is set, so out_data
   // can come straight from the register without a mask.
   always_comb begin
      mainV_d     = mainV_q;
      mainD_d     = mainD_q;
      skidV_d     = skidV_q;
      skidD_d     = skidD_q;
      bubbleCnt_d = bubbleCnt_q;

      if (flush) begin
         mainV_d = 1'b0;
         skidV_d = 1'b0;
         if (ZERO_BUBBLE != 0) begin
            mainD_d = '0;
         end
      end else if (take) begin
         if (skidV_q) begin
            mainD_d = skidD_q;
            skidV_d = 1'b0;
         end else if (accept) begin
            mainD_d = in_data;
         end else begin
            mainV_d = 1'b0;
            if (ZERO_BUBBLE != 0) begin
               mainD_d = '0;
            end
         end
      end else if (accept) begin
         if (!mainV_q) begin
            mainV_d = 1'b1;
            mainD_d = in_data;
         end else begin
            skidV_d = 1'b1;
            skidD_d = in_data;
         end
      end

      occ_d = {1'b0, mainV_d} + {1'b0, skidV_d};

      // Counts every cycle the output is empty, flush or not.
      if (!mainV_q && !(&bubbleCnt_q)) begin
         bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mainV_q     <= 1'b0;
         mainD_q     <= '0;
         skidV_q     <= 1'b0;
         skidD_q     <= '0;
         occ_q       <= 2'd0;
         bubbleCnt_q <= '0;
      end else begin
         mainV_q     <= mainV_d;
         mainD_q     <= mainD_d;
         skidV_q     <= skidV_d;
         skidD_q     <= skidD_d;
         occ_q       <= occ_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign out_valid  = mainV_q;
   assign out_data   = mainD_q;
   assign occupancy  = occ_q;
   assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a queue models the held entries in order,
// and a second instance with a 4-bit counter exercises bubble saturation.
module tb_pipe_stage;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        inValid;
   logic [31:0] inData;
   logic        outReady;

   logic        inReady;
   logic        outValid;
   logic [31:0] outData;
   logic [1:0]  occupancy;
   logic [15:0] bubbleCnt;

   logic        satInReady;
   logic        satOutValid;
   logic [31:0] satOutData;
   logic [1:0]  satOccupancy;
   logic [3:0]  satBubbleCnt;

   int          nCompared;
   int          nMismatched;

   logic [31:0] sbQueue[$];
   logic [15:0] modelCnt;
   logic [3:0]  modelSatCnt;

   pipe_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (inValid),
      .in_data    (inData),
      .in_ready   (inReady),
      .out_valid  (outValid),
      .out_data   (outData),
      .out_ready  (outReady),
      .occupancy  (occupancy),
      .bubble_cnt (bubbleCnt)
   );

   pipe_stage #(.CNT_W(4)) dutSat (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (inValid),
      .in_data    (inData),
      .in_ready   (satInReady),
      .out_valid  (satOutValid),
      .out_data   (satOutData),
      .out_ready  (outReady),
      .occupancy  (satOccupancy),
      .bubble_cnt (satBubbleCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle at the falling edge, checks the settled outputs against the
   // model, then advances the model to the state the next rising edge produces.
   task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                                input logic iv, input logic [31:0] d, input logic ordy);
      logic        expReady;
      logic        expValid;
      logic [31:0] expData;
      logic        mTake;
      logic        mAccept;
      logic [31:0] popped;
      @(negedge clk);
      rst      = r;
      flush    = f;
      stall    = s;
      inValid  = iv;
      inData   = d;
      outReady = ordy;
      #1;
      expValid = (sbQueue.size() > 0);
      expData  = expValid ? sbQueue[0] : 32'h0;
      expReady = (sbQueue.size() < 2) && !s[2] && !f;
      checkOutput("in_ready",   {31'b0, inReady},   {31'b0, expReady});
      checkOutput("out_valid",  {31'b0, outValid},  {31'b0, expValid});
      checkOutput("out_data",   outData,            expData);
      checkOutput("occupancy",  {30'b0, occupancy}, sbQueue.size());
      checkOutput("bubble_cnt", {16'b0, bubbleCnt}, {16'b0, modelCnt});
      checkOutput("sat_bubble", {28'b0, satBubbleCnt}, {28'b0, modelSatCnt});

      if (r) begin
         sbQueue.delete();
         modelCnt    = 16'h0;
         modelSatCnt = 4'h0;
      end else begin
         if (!expValid) begin
            if (modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'h1;
            if (modelSatCnt != 4'hF) modelSatCnt = modelSatCnt + 4'h1;
         end
         if (f) begin
            sbQueue.delete();
         end else begin
            mTake   = expValid && ordy && !s[3];
            mAccept = iv && expReady;
            if (mTake) begin
               popped = sbQueue.pop_front();
               checkOutput("sb_data", outData, popped);
            end
            if (mAccept) sbQueue.push_back(d);
         end
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      stall    = 6'b0;
      inValid  = 1'b0;
      inData   = 32'h0;
      outReady = 1'b0;
      repeat (2) @(posedge clk);
      modelCnt    = 16'h0;
      modelSatCnt = 4'h0;

      // Streaming with one-cycle latency.
      applyStimulus(0, 0, 6'b000000, 1, 32'h11, 1);
      applyStimulus(0, 0, 6'b000000, 1, 32'h22, 1);
      applyStimulus(0, 0, 6'b000000, 1, 32'h33, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0,  1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0,  1);

      // Backpressure into the skid entry, then drain in order.
      applyStimulus(0, 0, 6'b000000, 1, 32'hA, 0);
      applyStimulus(0, 0, 6'b000000, 1, 32'hB, 0);
      applyStimulus(0, 0, 6'b000000, 1, 32'hC, 0);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);

      // Bubble: own stall drains main with no refill.
      applyStimulus(0, 0, 6'b000000, 1, 32'h5, 0);
      applyStimulus(0, 0, 6'b000100, 1, 32'h6, 1);
      applyStimulus(0, 0, 6'b000100, 1, 32'h7, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);

      // Hold: own and downstream stall freeze everything.
      applyStimulus(0, 0, 6'b000000, 1, 32'h5, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'b001100, 1, 32'h9, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);

      // Flush with a full stage and a competing in_valid.
      applyStimulus(0, 0, 6'b000000, 1, 32'hD1, 0);
      applyStimulus(0, 0, 6'b000000, 1, 32'hD2, 0);
      applyStimulus(0, 1, 6'b000000, 1, 32'hD3, 1);
      applyStimulus(0, 0, 6'b000000, 0, 32'h0,  0);

      // Reset mid-operation with flush and handshakes active.
      applyStimulus(0, 0, 6'b000000, 1, 32'hE1, 0);
      applyStimulus(0, 0, 6'b000000, 1, 32'hE2, 0);
      applyStimulus(1, 1, 6'b001100, 1, 32'hE3, 1);

      // Long empty stretch saturates the 4-bit counter.
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);

      // Random traffic with occasional stalls, flushes and resets.
      for (int i = 0; i < 300; i++) begin
         logic [5:0] s;
         s    = 6'($urandom);
         s[2] = ($urandom_range(0, 3) == 0);
         s[3] = ($urandom_range(0, 3) == 0);
         applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), s,
                       1'($urandom), $urandom, ($urandom_range(0, 2) != 0));
      end
      applyStimulus(0, 0, 6'b000000, 0, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, payload width.
- STALL_W, default 6, stall vector width.
- STAGE, default 2, index of this stage's own stall bit.
- ZERO_BUBBLE, default 1, zero payload when the stage is empty.
- CNT_W, default 16, bubble counter width.
REQ-002 Legal parameters SHALL satisfy 0 <= STAGE <= STALL_W-2 and DATA_W >= 1; elaboration SHALL fail otherwise.
REQ-003 Ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; bit STAGE = own stall, bit STAGE+1 = downstream stall.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  main entry valid.
- out_data  out  DATA_W  main entry payload.
- out_ready  in  1  downstream accepts.
- occupancy  out  2  entries held (0..2).
- bubble_cnt  out  CNT_W  saturating count of empty-output cycles.

Function
REQ-004 Storage SHALL be a main entry (main_v, main_d) driving out_valid/out_data, plus one skid entry (skid_v, skid_d).
REQ-005 in_ready SHALL be !skid_v && !stall[STAGE] && !flush, combinational from state and inputs.
REQ-006 accept = in_valid && in_ready; take = main_v && out_ready && !stall[STAGE+1].
REQ-007 take with skid_v: skid SHALL move to main; skid_v SHALL clear.
REQ-008 take without skid_v: main SHALL load in_data if accept, else main_v SHALL clear.
REQ-009 No take, main_v=0, accept: main SHALL load in_data; main_v SHALL be set.
REQ-010 No take, main_v=1, accept: skid SHALL load in_data; skid_v SHALL be set.
REQ-011 No take, no accept: main and skid SHALL hold.
REQ-012 Bubble: stall[STAGE]=1 with stall[STAGE+1]=0 SHALL let the main entry drain with no refill, so out_valid is 0 the cycle after the take.
REQ-013 Hold: stall[STAGE]=1 with stall[STAGE+1]=1 SHALL leave all state unchanged.
REQ-014 Whenever main_v is 0 and ZERO_BUBBLE=1, out_data SHALL be all zeros; with ZERO_BUBBLE=0 it SHALL keep its last value.
REQ-015 Skid payload SHALL never be visible on out_data until promoted to main.
REQ-016 Data SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush/rst.
REQ-017 Latency SHALL be exactly 1 cycle from accept to out_valid when the stage is empty.
REQ-018 flush=1 SHALL clear main_v and skid_v next cycle, zero main_d when ZERO_BUBBLE=1, and ignore in_valid that cycle.
REQ-019 Priority SHALL be rst > flush > take/accept.
REQ-020 occupancy SHALL equal main_v + skid_v, registered with the entries.
REQ-021 bubble_cnt SHALL increment each cycle out_valid=0, saturate at all-ones, and be unaffected by flush.
REQ-022 occupancy=2 SHALL force in_ready=0; occupancy=0 SHALL force out_valid=0.

Reset
REQ-023 With rst=1 at a clock edge, main_v, skid_v, occupancy and bubble_cnt SHALL be 0 and main_d, skid_d all zeros.
REQ-024 Mid-operation rst SHALL discard both entries regardless of stall, flush or handshake inputs.
REQ-025 First cycle after reset release: in_ready=!stall[STAGE], out_valid=0.

Verification
REQ-026 Streaming: stall=0, out_ready=1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, occupancy<=1.
REQ-027 Backpressure: load 0xA, out_ready=0, offer 0xB -> occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB, no loss.
REQ-028 Bubble: main=0x5, stall=6'b000100, in_valid=1 -> out_valid drops next cycle, out_data=0, bubble_cnt+1, in_ready=0.
REQ-029 Hold: main=0x5, stall=6'b001100, 3 cycles -> out_data=0x5 and out_valid=1 throughout, occupancy constant.
REQ-030 Flush/reset: occupancy=2, flush=1 with in_valid=1 -> occupancy=0, out_data=0; repeat with rst=1 -> bubble_cnt=0 too.
REQ-031 Saturation: CNT_W=4, 20 empty cycles -> bubble_cnt=4'hF held.
